// File: rtl/rd_burst_deser_pkg.sv
// Shared constants for the DDR read-burst deserializer.
package rd_burst_deser_pkg;
    localparam int DDR5_BL       = 16;  // BL16 burst length
    localparam int DEFAULT_WIDTH = 8;   // default DQ beat width
endpackage

// File: rtl/rd_burst_deser_fifo2.sv
// Two-entry output buffer; accepts a push while full when a pop happens in the same cycle.
module fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [1:0]   count_reg;
    logic [W-1:0] head_reg;
    logic [W-1:0] tail_reg;
    logic         push;
    logic         pop;

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = head_reg;
    assign pop       = out_valid && out_ready;
    assign in_ready  = (count_reg != 2'd2) || out_ready;
    assign push      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 2'd0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) head_reg <= in_data;
                    else                   tail_reg <= in_data;
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    head_reg  <= tail_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (count_reg == 2'd2) begin
                        head_reg <= tail_reg;
                        tail_reg <= in_data;
                    end else begin
                        head_reg <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/rd_burst_deser.sv
// Collects returned DQ beats into full read-burst words, tracks outstanding read credits.
module rd_burst_deser
    import rd_burst_deser_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int BURST   = DDR5_BL,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_issue,
    output logic                   issue_ready,
    input  logic                   beat_valid,
    input  logic [WIDTH-1:0]       beat_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*BURST-1:0] out_data,
    input  logic                   err_clr,
    output logic                   ovf_err,
    output logic                   unexp_err,
    output logic                   issue_err
);
    localparam int CW = $clog2(BURST);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [CW-1:0]                 beat_cnt;
    logic [OW-1:0]                 outstanding;
    logic [BURST-2:0][WIDTH-1:0]   asm_reg;
    logic [BURST-1:0][WIDTH-1:0]   word;
    logic                          accept_beat;
    logic                          complete;
    logic                          issue_acc;
    logic                          fifo_in_ready;
    logic                          ovf_event;
    logic                          unexp_event;
    logic                          issue_event;

    assign issue_ready = (outstanding < OW'(MAX_OUT));
    assign issue_acc   = rd_issue && issue_ready;
    assign issue_event = rd_issue && !issue_ready;
    assign accept_beat = beat_valid && (outstanding != '0);
    assign unexp_event = beat_valid && (outstanding == '0);
    assign complete    = accept_beat && (beat_cnt == CW'(BURST - 1));
    assign ovf_event   = complete && !fifo_in_ready;

    // The final beat bypasses the assembly register so the word is pushed the cycle it arrives.
    genvar gi;
    generate
        for (gi = 0; gi < BURST - 1; gi++) begin : g_slot
            assign word[gi] = asm_reg[gi];
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    asm_reg[gi] <= '0;
                else if (accept_beat && beat_cnt == CW'(gi))
                    asm_reg[gi] <= beat_data;
            end
        end
    endgenerate
    assign word[BURST-1] = beat_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt    <= '0;
            outstanding <= '0;
        end else begin
            if (accept_beat)
                beat_cnt <= complete ? '0 : beat_cnt + CW'(1);
            if (issue_acc && !complete)
                outstanding <= outstanding + OW'(1);
            else if (complete && !issue_acc)
                outstanding <= outstanding - OW'(1);
        end
    end

    // Error events take priority over err_clr in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err   <= 1'b0;
            unexp_err <= 1'b0;
            issue_err <= 1'b0;
        end else begin
            if (ovf_event)    ovf_err   <= 1'b1;
            else if (err_clr) ovf_err   <= 1'b0;
            if (unexp_event)  unexp_err <= 1'b1;
            else if (err_clr) unexp_err <= 1'b0;
            if (issue_event)  issue_err <= 1'b1;
            else if (err_clr) issue_err <= 1'b0;
        end
    end

    fifo2 #(.W(WIDTH * BURST)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (complete),
        .in_ready  (fifo_in_ready),
        .in_data   (word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );
endmodule
